// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button debounce front end.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  // Defaults assume a 100 MHz system clock.
  localparam int unsigned DEF_DB_CYCLES     = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10_000_000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle between the board pins and the debounce block.
interface btn_debounce_if #(
  parameter int unsigned NUM_BTN = 5
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (output btn_raw, input btn_level, btn_press, btn_release);
  modport slave  (input btn_raw, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM and, when BTN_REPEAT_EN
// is defined, an auto-repeat counter that re-pulses press while the button is held.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("DB_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  localparam int unsigned     CW     = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]   DB_MAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sync;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          level_q, level_d;
  logic          accept_press;
  logic          rep_pulse;

  assign sync = sync_q[1];

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept_press = 1'b0;
    release_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == DB_MAX) begin
          state_d      = HELD;
          accept_press = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt_q == DB_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign press_d = accept_press | rep_pulse;
  assign level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      level_q   <= level_d;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned    REP_N      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                        : REPEAT_PERIOD;
  localparam int unsigned    RCW        = cnt_width(REP_N);
  localparam logic [RCW-1:0] DELAY_MAX  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_MAX = RCW'(REPEAT_PERIOD - 1);

  logic [RCW-1:0] rep_q, rep_d;
  logic           rep_arm_q, rep_arm_d;

  // rep_arm_q selects the period once the first (longer) delay has elapsed.
  always_comb begin
    rep_d     = rep_q;
    rep_arm_d = rep_arm_q;
    rep_pulse = 1'b0;
    if (state_q == HELD && sync) begin
      if (rep_q == (rep_arm_q ? PERIOD_MAX : DELAY_MAX)) begin
        rep_pulse = 1'b1;
        rep_d     = '0;
        rep_arm_d = 1'b1;
      end else begin
        rep_d = rep_q + RCW'(1);
      end
    end else if (state_d == IDLE) begin
      rep_d     = '0;
      rep_arm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_q     <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_q     <= rep_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounce/edge-detect front end for NUM_BTN independent push-buttons.
// Define BTN_REPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN       = 5,
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic           clk,
  input  logic           rst_n,
  btn_debounce_if.slave  btn
);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] press_w;
  logic [NUM_BTN-1:0] release_w;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (btn.btn_raw[i]),
      .level_o  (level_w[i]),
      .press_o  (press_w[i]),
      .release_o(release_w[i])
    );
  end

  assign btn.btn_level   = level_w;
  assign btn.btn_press   = press_w;
  assign btn.btn_release = release_w;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: vector table, directed corner cases and
// randomized stimulus against a run-length reference model.
module tb_btn_debounce;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  btn_debounce_if #(.NUM_BTN(NB)) bus();

  btn_debounce #(
    .NUM_BTN      (NB),
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: accepted level plus length of the current disagreeing run.
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_rel = '0;
  int m_run [NB];
  int m_held[NB];

  int press_cnt[NB];
  int rel_cnt  [NB];
  bit lvl_seen [NB];
  int press_at0[$];
  int rel_at0;

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] level;
  } vec_t;
  vec_t vt[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic sync;
    for (int c = 0; c < NB; c++) begin
      m_press[c] = 1'b0;
      m_rel[c]   = 1'b0;
      if (!rst_n) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
        m_run[c] = 0;   m_held[c] = 0;
      end else begin
        sync    = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = bus.btn_raw[c];
        if (sync != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_lvl[c]  = sync;
            m_run[c]  = 0;
            m_held[c] = 0;
            if (sync) m_press[c] = 1'b1;
            else      m_rel[c]   = 1'b1;
          end
        end else begin
          if (m_lvl[c] && m_run[c] == 0) begin
            m_held[c]++;
            if (REP_EN && m_held[c] >= RD && (m_held[c] - RD) % RP == 0) m_press[c] = 1'b1;
          end
          m_run[c] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check("level",   bus.btn_level,   m_lvl);
    check("press",   bus.btn_press,   m_press);
    check("release", bus.btn_release, m_rel);
    for (int c = 0; c < NB; c++) begin
      if (bus.btn_press[c] === 1'b1) begin
        press_cnt[c]++;
        if (c == 0) press_at0.push_back(cyc);
      end
      if (bus.btn_release[c] === 1'b1) begin
        rel_cnt[c]++;
        if (c == 0) rel_at0 = cyc;
      end
      if (bus.btn_level[c] === 1'b1) lvl_seen[c] = 1'b1;
    end
  endtask

  task automatic clear_logs();
    for (int c = 0; c < NB; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c]   = 0;
      lvl_seen[c]  = 1'b0;
    end
    press_at0.delete();
    rel_at0 = -1;
  endtask

  task automatic go_idle();
    bus.btn_raw = '0;
    repeat (12) tick();
    clear_logs();
  endtask

  initial begin
    int s, r, len;
    int exp_at[$];
    int pat[5] = '{1, 0, 1, 0, 1};

    for (int i = 0; i < 20; i++) begin
      vt[i].raw   = (i < 10) ? 2'b11 : 2'b00;
      vt[i].press = (i == 6) ? 2'b11 : 2'b00;
      vt[i].rel   = (i == 16) ? 2'b11 : 2'b00;
      vt[i].level = (i >= 6 && i < 16) ? 2'b11 : 2'b00;
    end

    rst_n       = 1'b0;
    bus.btn_raw = '0;
    clear_logs();
    repeat (3) tick();
    check("reset_state", {bus.btn_level, bus.btn_press, bus.btn_release}, '0);
    rst_n = 1'b1;
    go_idle();

    // Simultaneous press/release on both channels from the vector table.
    for (int i = 0; i < 20; i++) begin
      bus.btn_raw = vt[i].raw;
      tick();
      check("tbl_press",   bus.btn_press,   vt[i].press);
      check("tbl_release", bus.btn_release, vt[i].rel);
      check("tbl_level",   bus.btn_level,   vt[i].level);
    end
    go_idle();

    // Clean press held 30 cycles, then release.
    s = cyc + 1;
    bus.btn_raw = 2'b01;
    repeat (30) tick();
    bus.btn_raw = 2'b00;
    r = cyc + 1;
    repeat (12) tick();
    check("clean_press_cnt", press_cnt[0], REP_EN ? 2 : 1);
    check("clean_press_at",  (press_at0.size() > 0) ? press_at0[0] : -1, s + 6);
    check("clean_rel_cnt",   rel_cnt[0], 1);
    check("clean_rel_at",    rel_at0, r + 6);
    go_idle();

    // Bounce then hold.
    s = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      bus.btn_raw = {1'b0, pat[i][0]};
      tick();
    end
    bus.btn_raw = 2'b01;
    repeat (15) tick();
    check("bounce_press_cnt", press_cnt[0], 1);
    check("bounce_press_at",  (press_at0.size() > 0) ? press_at0[0] : -1, s + 10);
    go_idle();

    // Short glitch on channel 1.
    bus.btn_raw = 2'b10;
    repeat (3) tick();
    bus.btn_raw = 2'b00;
    repeat (10) tick();
    check("glitch_press_cnt", press_cnt[1], 0);
    check("glitch_level",     lvl_seen[1], 1'b0);
    go_idle();

    // Reset while in PRESS_WAIT with the button held throughout.
    bus.btn_raw = 2'b01;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_out", {bus.btn_level, bus.btn_press, bus.btn_release}, '0);
    rst_n = 1'b1;
    r = cyc + 1;
    repeat (10) tick();
    check("rst_press_cnt", press_cnt[0], 1);
    check("rst_press_at",  (press_at0.size() > 0) ? press_at0[0] : -1, r + 6);
    check("rst_rel_cnt",   rel_cnt[0], 0);
    go_idle();

    // Long hold: auto-repeat pulses when enabled, one pulse otherwise.
    s = cyc + 1;
    bus.btn_raw = 2'b01;
    repeat (56) tick();
    exp_at = {s + 6};
    if (REP_EN) begin
      exp_at.push_back(s + 26);
      exp_at.push_back(s + 34);
      exp_at.push_back(s + 42);
      exp_at.push_back(s + 50);
    end
    check("repeat_cnt", press_at0.size(), exp_at.size());
    for (int i = 0; i < exp_at.size(); i++)
      check("repeat_at", (i < press_at0.size()) ? press_at0[i] : -1, exp_at[i]);
    go_idle();

    // Randomized segments, including long holds and occasional resets.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) != 0) bus.btn_raw = NB'($urandom);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 9);
      if ($urandom_range(0, 30) == 0) rst_n = 1'b0;
      repeat (len) tick();
      rst_n = 1'b1;
    end
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
